delay_line_ctrl: RTL
====================

Name: delay_line_ctrl

Overview:
- Controller that sequences one dual-port RAM (one synchronous write port, one synchronous-read port; 2^ADDRESS_WIDTH words of DATA_WIDTH bits) as a circular sample delay line.
- Each accepted input sample is written to the RAM. Once the line holds `delay` samples, the controller reads back the sample accepted `delay` samples earlier and presents it with a valid strobe.
- Sits between the sample source (e.g. audio/ADC path) and the signal output path, and owns every RAM control/address signal.

Parameters:
- ADDRESS_WIDTH, 8, RAM address width; pointer/counter width; maximum delay 2^ADDRESS_WIDTH-1.
- DATA_WIDTH, 8, sample width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous restart of the delay line; returns to IDLE.
- delay  in  ADDRESS_WIDTH  requested delay in samples; sampled only in IDLE.
- in_valid  in  1  in_data holds a new sample this cycle.
- in_data  in  DATA_WIDTH  input sample.
- out_valid  out  1  out_data holds a new delayed sample this cycle (1-cycle pulse per sample).
- out_data  out  DATA_WIDTH  delayed sample; holds its last value between pulses.
- filling  out  1  high while state != RUN.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDRESS_WIDTH  RAM write address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDRESS_WIDTH  RAM read address.
- ram_dout  in  DATA_WIDTH  RAM read data; valid 1 cycle after ram_rd_en is sampled.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, evaluated at the clock edge:
  - state=IDLE, wr_ptr=0, fill_cnt=0, delay_q=0.
  - Read pipeline flags cleared; out_valid=0, out_data=0, filling=1.
  - RAM contents are not cleared.
- States:
  - IDLE: no data yet.
  - FILL: writing, no reads.
  - RUN: write plus read per sample.
- Effective delay: d_eff = (delay==0) ? 1 : delay. It is latched into delay_q on the IDLE cycle that accepts the first sample.
- RAM drive is combinational from state, pointers and in_valid:
  - ram_wr_en = in_valid & ~flush & ~rst.
  - ram_wr_addr = wr_ptr; ram_din = in_data.
  - ram_rd_en = ram_wr_en & (state==RUN).
  - ram_rd_addr = wr_ptr - delay_q, modulo 2^ADDRESS_WIDTH.
- Read/write address collision is impossible, since 1 <= delay_q <= 2^AW-1.
- Per accepted sample (ram_wr_en=1): wr_ptr <= wr_ptr+1, wrapping 2^AW-1 -> 0.
- IDLE -> accepted sample:
  - fill_cnt <= 1.
  - Next state is RUN if d_eff==1, else FILL.
- FILL -> accepted sample:
  - fill_cnt <= fill_cnt+1.
  - Go to RUN when fill_cnt+1 == delay_q.
- RUN: stays in RUN; fill_cnt frozen.
- Result: output for input index n (n >= delay_q) equals input n-delay_q.
- Latency: a read issued in cycle N gives ram_dout in N+1.
  - out_data <= ram_dout at the end of N+1.
  - out_valid=1 during N+2 only (two-stage valid pipeline: rd_en -> v1 -> out_valid).
- Back-to-back in_valid gives one out_valid per cycle. Gaps in in_valid advance nothing and produce matching gaps at the output.
- delay changes outside IDLE are ignored until the next flush/reset.
- flush:
  - Next state=IDLE; wr_ptr=0, fill_cnt=0.
  - Valid pipeline cleared, so no out_valid for reads in flight; out_valid=0 from the next cycle.
  - out_data keeps its value.
- flush with in_valid in the same cycle: flush wins, no RAM write, sample dropped.
- rst has priority over flush; rst mid-operation behaves like flush and also clears out_data.
- filling is registered-state derived: 1 in IDLE/FILL, 0 in RUN.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> ram_wr_en=0, ram_rd_en=0, out_valid=0, out_data=0, filling=1.
- Basic delay: delay=3, in_valid continuous, data 1,2,3,...
  - Inputs 1..3 give no ram_rd_en; filling drops after input 3.
  - Input 4 in cycle N -> out_valid at N+2 with out_data=1, then 2,3,... on consecutive cycles.
- Zero clamp: delay=0, inputs 10,20,30 back-to-back -> outputs 10 then 20, each 2 cycles after inputs 20 and 30; ram_rd_addr = ram_wr_addr-1.
- Wrap: AW=8, delay=255, 600 inputs with value n&0xFF -> every output equals (n-255)&0xFF, checked across wr_ptr wraps at 256 and 512; no write/read address equality.
- Gapped input: delay=2, in_valid every other cycle, data 5,6,7,8 -> out_valid pulses only 2 cycles after inputs 7 and 8 (values 5,6); wr_ptr unchanged in gap cycles.
- Flush: in RUN with a read in flight, assert flush together with in_valid and set delay=5.
  - No RAM write that cycle; no out_valid on the following 2 cycles.
  - filling=1; the next 5 inputs give no output.
  - The 6th input's output equals the 1st post-flush input.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
//   Sequences one dual-port RAM (synchronous write port, synchronous read
//   port, 2^ADDRESS_WIDTH words) as a circular sample delay line. Every
//   accepted input sample is written at wr_ptr. Once `delay` samples have
//   been stored, each new write is paired with a read of the sample accepted
//   `delay` samples earlier. That sample reaches out_data two cycles later.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   flush        synchronous restart of the delay line (back to IDLE)
//   delay        requested delay in samples, sampled only in IDLE (0 acts as 1)
//   in_valid     in_data carries a new sample this cycle
//   in_data      input sample
//   out_valid    one-cycle pulse per delayed sample
//   out_data     delayed sample, holds its value between pulses
//   filling      high while the line is not yet in RUN
//   ram_wr_en    RAM write enable
//   ram_wr_addr  RAM write address
//   ram_din      RAM write data
//   ram_rd_en    RAM read enable
//   ram_rd_addr  RAM read address
//   ram_dout     RAM read data, valid one cycle after ram_rd_en
//
// Handshake: there is no back-pressure. A sample is accepted in any cycle
// where in_valid=1 and neither flush nor rst is asserted. out_valid is a
// one-cycle strobe with no ready; the consumer must take out_data that cycle.

module delay_line_ctrl #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     filling,
    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    localparam logic [ADDRESS_WIDTH-1:0] ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] fill_cnt;
    logic [ADDRESS_WIDTH-1:0] delay_q;
    logic [ADDRESS_WIDTH-1:0] d_eff;
    logic                     v1;
    logic                     wr_en;

    // A zero delay would make the read and write addresses collide, so it
    // is clamped to one sample.
    assign d_eff = (delay == '0) ? ONE : delay;
    assign wr_en = in_valid & ~flush & ~rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (wr_en) begin
            case (state_q)
                IDLE: state_d = (d_eff == ONE) ? RUN : FILL;
                FILL: if (fill_cnt + ONE == delay_q) state_d = RUN;
                RUN:  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: RAM drive is purely combinational from registered state
    always_comb begin
        filling     = (state_q != RUN);
        ram_wr_en   = wr_en;
        ram_wr_addr = wr_ptr;
        ram_din     = in_data;
        ram_rd_en   = wr_en & (state_q == RUN);
        // Modulo subtraction wraps naturally at 2^ADDRESS_WIDTH.
        ram_rd_addr = wr_ptr - delay_q;
    end

    // Pointers, fill counter and the two-stage read-valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            delay_q   <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            // Reads in flight are discarded; out_data keeps the last sample.
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= ram_rd_en;
            out_valid <= v1;
            if (v1) begin
                out_data <= ram_dout;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
                case (state_q)
                    IDLE: begin
                        fill_cnt <= ONE;
                        delay_q  <= d_eff;
                    end
                    FILL:    fill_cnt <= fill_cnt + ONE;
                    default: fill_cnt <= fill_cnt;
                endcase
            end
        end
    end

endmodule
